// File: rtl/iic_burst_seq_pkg.sv
// Shared types and widths for the key-driven IIC burst sequencer.
package iic_seq_pkg;

  localparam int IIC_ADDR_W = 16;
  localparam int IIC_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    GAP,
    DONE
  } state_t;

  typedef enum logic {
    WR,
    RD
  } mode_t;

  // Register address of burst slot idx; 8-bit mode wraps in the low byte only.
  function automatic logic [IIC_ADDR_W-1:0] burst_addr(input logic [IIC_ADDR_W-1:0] base,
                                                       input logic [7:0] idx,
                                                       input bit a16);
    logic [IIC_ADDR_W-1:0] sum;
    sum = base + {8'h00, idx};
    return a16 ? sum : {8'h00, sum[7:0]};
  endfunction

endpackage

// File: rtl/iic_burst_seq_if.sv
// Sequencer <-> IIC byte driver bus, plus the captured read-byte report.
interface iic_burst_seq_if;
  import iic_seq_pkg::*;

  logic                  wr_en;
  logic                  rd_en;
  logic                  iic_start;
  logic                  addr_mem;
  logic [IIC_ADDR_W-1:0] data_addr;
  logic [IIC_DATA_W-1:0] wr_data;
  logic                  iic_wr_rd_done;
  logic [IIC_DATA_W-1:0] iic_rd_data;
  logic                  rd_valid;
  logic [IIC_DATA_W-1:0] rd_data;
  logic [IIC_ADDR_W-1:0] rd_addr;

  modport master (
    output wr_en, rd_en, iic_start, addr_mem, data_addr, wr_data,
    output rd_valid, rd_data, rd_addr,
    input  iic_wr_rd_done, iic_rd_data
  );

  modport slave (
    input  wr_en, rd_en, iic_start, addr_mem, data_addr, wr_data,
    input  rd_valid, rd_data, rd_addr,
    output iic_wr_rd_done, iic_rd_data
  );

endinterface

// File: rtl/iic_burst_seq_key_debounce.sv
// Active-low key debouncer: one flag pulse per press held for DEBOUNCE_CYC-1 cycles.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic flag
);

  localparam int            CW       = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_FIRE = CW'(DEBOUNCE_CYC - 2);

  logic [CW-1:0] cnt;

  // Saturating at CNT_MAX means a long hold never re-crosses CNT_FIRE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (key_n)          cnt <= '0;
    else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
  end

  assign flag = (cnt == CNT_FIRE);

endmodule

// File: rtl/iic_burst_seq.sv
// Key-driven IIC burst sequencer: BURST_LEN single-byte transactions from BASE_ADDR.
// Optional per-transaction WAIT timeout with sticky err is enabled by defining IIC_TIMEOUT_EN.
module iic_burst_seq
  import iic_seq_pkg::*;
#(
  parameter int                    DEBOUNCE_CYC = 100000,
  parameter int                    BURST_LEN    = 4,
  parameter logic [IIC_ADDR_W-1:0] BASE_ADDR    = 16'h005A,
  parameter logic [IIC_DATA_W-1:0] WR_SEED      = 8'h55,
  parameter bit                    ADDR_16B     = 1'b1,
  parameter int                    TIMEOUT_CYC  = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_wr,
  input  logic            key_rd,
  iic_burst_seq_if.master bus,
  output logic            busy,
  output logic            err
);

  localparam logic [7:0]            IDX_LAST = 8'(BURST_LEN - 1);
  localparam logic [IIC_ADDR_W-1:0] ADDR_RST = burst_addr(BASE_ADDR, 8'h00, ADDR_16B);

  state_t     state, state_nxt;
  mode_t      mode;
  logic [7:0] idx;
  logic       flag_wr, flag_rd;
  logic       done, last, timeout_hit;
  logic       accept, do_load, ack, abort;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_wr (
    .clk(clk), .rst(rst), .key_n(key_wr), .flag(flag_wr)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_rd (
    .clk(clk), .rst(rst), .key_n(key_rd), .flag(flag_rd)
  );

  assign done          = bus.iic_wr_rd_done;
  assign last          = (idx == IDX_LAST);
  assign bus.addr_mem  = ADDR_16B;

`ifdef IIC_TIMEOUT_EN
  localparam int            TW     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                tcnt <= '0;
    else if (state == LOAD) tcnt <= '0;
    else if (state == WAIT) tcnt <= tcnt + TW'(1);
  end

  assign timeout_hit = (state == WAIT) && (tcnt == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err <= 1'b0;
    else if (accept) err <= 1'b0;
    else if (abort)  err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (flag_wr || flag_rd) state_nxt = LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT: begin
        if (done)             state_nxt = last ? DONE : GAP;
        else if (timeout_hit) state_nxt = DONE;
      end
      GAP:     state_nxt = LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    do_load = 1'b0;
    ack     = 1'b0;
    abort   = 1'b0;
    busy    = (state != IDLE);
    unique case (state)
      IDLE:    accept  = flag_wr || flag_rd;
      LOAD:    do_load = 1'b1;
      WAIT: begin
        ack   = done;
        abort = timeout_hit && !done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode          <= WR;
      idx           <= 8'h00;
      bus.iic_start <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.data_addr <= ADDR_RST;
      bus.wr_data   <= WR_SEED;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
      bus.rd_addr   <= '0;
    end else begin
      bus.rd_valid <= 1'b0;
      if (accept) begin
        // Write key wins a same-cycle tie.
        mode <= flag_wr ? WR : RD;
        idx  <= 8'h00;
      end
      if (do_load) begin
        bus.iic_start <= 1'b1;
        bus.wr_en     <= (mode == WR);
        bus.rd_en     <= (mode == RD);
        bus.data_addr <= burst_addr(BASE_ADDR, idx, ADDR_16B);
        bus.wr_data   <= WR_SEED + idx;
      end
      if (ack) begin
        bus.iic_start <= 1'b0;
        bus.wr_en     <= 1'b0;
        bus.rd_en     <= 1'b0;
        if (mode == RD) begin
          bus.rd_data  <= bus.iic_rd_data;
          bus.rd_addr  <= bus.data_addr;
          bus.rd_valid <= 1'b1;
        end
        if (!last) idx <= idx + 8'd1;
      end
      if (abort) begin
        bus.iic_start <= 1'b0;
        bus.wr_en     <= 1'b0;
        bus.rd_en     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iic_burst_seq.sv
// Scoreboard bench for iic_burst_seq: randomized bursts against a transaction-level model.
module tb_iic_burst_seq;
  import iic_seq_pkg::*;

  localparam int DEB = 16;
  localparam int BL  = 4;
  localparam int TO  = 64;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  logic key_wr, key_rd, busy, err;
  logic key_wr_b, key_rd_b, busy_b, err_b;

  iic_burst_seq_if bus_a ();
  iic_burst_seq_if bus_b ();

  iic_burst_seq #(.DEBOUNCE_CYC(DEB), .BURST_LEN(BL), .BASE_ADDR(16'h005A), .WR_SEED(8'h55),
                  .ADDR_16B(1'b1), .TIMEOUT_CYC(TO)) dut_a (
    .clk(clk), .rst(rst), .key_wr(key_wr), .key_rd(key_rd), .bus(bus_a), .busy(busy), .err(err)
  );

  iic_burst_seq #(.DEBOUNCE_CYC(DEB), .BURST_LEN(BL), .BASE_ADDR(16'h00FE), .WR_SEED(8'h10),
                  .ADDR_16B(1'b0), .TIMEOUT_CYC(TO)) dut_b (
    .clk(clk), .rst(rst), .key_wr(key_wr_b), .key_rd(key_rd_b), .bus(bus_b), .busy(busy_b),
    .err(err_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int ack_dly = 5;
  bit ack_en = 1'b1;

  txn_t        exp_q[$];
  logic [15:0] exp_rd_addr[$];
  logic [7:0]  exp_rd_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_addr(input int base, input int i, input bit a16);
    if (a16) return 16'((base + i) % 65536);
    return 16'(((base % 256) + i) % 256);
  endfunction

  task automatic issue_burst(input bit wr);
    txn_t t;
    for (int i = 0; i < BL; i++) begin
      t.wr   = wr;
      t.addr = model_addr(16'h005A, i, 1'b1);
      t.data = 8'((8'h55 + i) % 256);
      exp_q.push_back(t);
      if (!wr) exp_rd_addr.push_back(t.addr);
    end
  endtask

  task automatic press_a(input bit rd_key, input int n);
    if (rd_key) key_rd = 1'b0;
    else        key_wr = 1'b0;
    repeat (n) @(negedge clk);
    key_wr = 1'b1;
    key_rd = 1'b1;
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: busy still %0b, required 0", name, busy);
    end
    check({name, "_exp_q_left"}, exp_q.size(), 0);
    check({name, "_rd_q_left"}, exp_rd_addr.size(), 0);
  endtask

  task automatic check_reset_a(input string name);
    check({name, "_wr_en"}, bus_a.wr_en, 0);
    check({name, "_rd_en"}, bus_a.rd_en, 0);
    check({name, "_start"}, bus_a.iic_start, 0);
    check({name, "_rd_valid"}, bus_a.rd_valid, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_err"}, err, 0);
    check({name, "_data_addr"}, bus_a.data_addr, 16'h005A);
    check({name, "_wr_data"}, bus_a.wr_data, 8'h55);
    check({name, "_rd_data"}, bus_a.rd_data, 0);
    check({name, "_rd_addr"}, bus_a.rd_addr, 0);
    check({name, "_addr_mem"}, bus_a.addr_mem, 1);
  endtask

  // Driver model for DUT A: ack after ack_dly cycles of iic_start, random read byte.
  initial begin
    int cnt = 0;
    bus_a.iic_wr_rd_done = 1'b0;
    bus_a.iic_rd_data    = 8'h00;
    forever begin
      @(negedge clk);
      if (rst || bus_a.iic_wr_rd_done) begin
        bus_a.iic_wr_rd_done = 1'b0;
        cnt = 0;
      end else if (bus_a.iic_start && ack_en) begin
        cnt++;
        if (cnt >= ack_dly) begin
          bus_a.iic_rd_data    = 8'($urandom);
          bus_a.iic_wr_rd_done = 1'b1;
          if (bus_a.rd_en) exp_rd_data.push_back(bus_a.iic_rd_data);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Driver model for DUT B: fixed 3-cycle ack.
  initial begin
    int cnt = 0;
    bus_b.iic_wr_rd_done = 1'b0;
    bus_b.iic_rd_data    = 8'h00;
    forever begin
      @(negedge clk);
      if (rst || bus_b.iic_wr_rd_done) begin
        bus_b.iic_wr_rd_done = 1'b0;
        cnt = 0;
      end else if (bus_b.iic_start) begin
        cnt++;
        if (cnt >= 3) bus_b.iic_wr_rd_done = 1'b1;
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: every rising iic_start and every rd_valid is matched against the model queues.
  initial begin
    logic prev = 1'b0;
    txn_t t;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        continue;
      end
      if (bus_a.iic_start && !prev) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: addr %0h, no transaction expected", bus_a.data_addr);
        end else begin
          t = exp_q.pop_front();
          check("txn_wr_en", bus_a.wr_en, t.wr);
          check("txn_rd_en", bus_a.rd_en, !t.wr);
          check("txn_addr", bus_a.data_addr, t.addr);
          check("txn_wr_data", bus_a.wr_data, t.data);
        end
      end
      prev = bus_a.iic_start;
      if (bus_a.rd_valid) begin
        if (exp_rd_addr.size() == 0 || exp_rd_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_valid: rd_addr %0h, no read expected", bus_a.rd_addr);
        end else begin
          check("rd_addr", bus_a.rd_addr, exp_rd_addr.pop_front());
          check("rd_data", bus_a.rd_data, exp_rd_data.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base_cnt;
    key_wr   = 1'b1;
    key_rd   = 1'b1;
    key_wr_b = 1'b1;
    key_rd_b = 1'b1;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_a("reset");
    check("reset_b_addr", bus_b.data_addr, 16'h00FE);
    check("reset_b_addr_mem", bus_b.addr_mem, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed write and read bursts.
    ack_dly = 5;
    issue_burst(1'b1);
    press_a(1'b0, 20);
    wait_idle_a("wr_burst");
    issue_burst(1'b0);
    press_a(1'b1, 20);
    wait_idle_a("rd_burst");

    // Short bounce gives nothing; the full press gives one burst; rd key mid-burst is dropped.
    press_a(1'b0, 10);
    repeat (2) @(negedge clk);
    base_cnt = start_cnt;
    issue_burst(1'b1);
    press_a(1'b0, 20);
    press_a(1'b1, 20);
    wait_idle_a("bounce");
    repeat (40) @(negedge clk);
    check("bounce_start_count", start_cnt - base_cnt, BL);
    check("bounce_busy_after", busy, 0);

    // Randomized bursts.
    for (int b = 0; b < 8; b++) begin
      bit wr;
      wr      = 1'($urandom);
      ack_dly = int'($urandom_range(1, 8));
      issue_burst(wr);
      press_a(!wr, int'($urandom_range(15, 30)));
      wait_idle_a("rand_burst");
      repeat (int'($urandom_range(1, 10))) @(negedge clk);
    end

    // 8-bit address wrap on DUT B.
    key_wr_b = 1'b0;
    for (int i = 0; i < BL; i++) begin
      n = 0;
      while (!bus_b.iic_start && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("b_start_seen", bus_b.iic_start, 1);
      check("b_addr", bus_b.data_addr, model_addr(16'h00FE, i, 1'b0));
      check("b_wr_data", bus_b.wr_data, 8'((8'h10 + i) % 256));
      check("b_addr_mem", bus_b.addr_mem, 0);
      n = 0;
      while (bus_b.iic_start && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (i == 0) key_wr_b = 1'b1;
    end
    repeat (5) @(negedge clk);
    check("b_busy_after", busy_b, 0);

    // Reset in WAIT of transaction 2, then a clean restart.
    ack_dly  = 6;
    base_cnt = start_cnt;
    issue_burst(1'b1);
    press_a(1'b0, 20);
    n = 0;
    while (start_cnt < base_cnt + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached", (start_cnt >= base_cnt + 3), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_a("rst_mid");
    exp_q.delete();
    exp_rd_addr.delete();
    exp_rd_data.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue_burst(1'b1);
    press_a(1'b0, 20);
    wait_idle_a("after_rst");

`ifdef IIC_TIMEOUT_EN
    begin
      txn_t t;
      ack_en = 1'b0;
      t.wr   = 1'b1;
      t.addr = 16'h005A;
      t.data = 8'h55;
      exp_q.push_back(t);
      key_wr = 1'b0;
      n = 0;
      while (!bus_a.iic_start && n < 200) begin
        @(negedge clk);
        n++;
      end
      key_wr = 1'b1;
      n = 0;
      while (bus_a.iic_start && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("timeout_wait_cycles", n, TO);
      wait_idle_a("timeout");
      check("timeout_err", err, 1);
      check("timeout_busy", busy, 0);
      ack_en  = 1'b1;
      ack_dly = 3;
      issue_burst(1'b1);
      press_a(1'b0, 20);
      wait_idle_a("timeout_recover");
      check("timeout_err_cleared", err, 0);
    end
`else
    check("err_constant", err, 0);
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
